// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT sequencer: controller states, frame size,
// sample word type and default engine timing.
package fft_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } ctrl_state_t;

    typedef logic [15:0] sample_t;

    localparam int BYTES_PER_FRAME = 8;
    localparam int ENG_LAT_DEFAULT = 5;
    localparam int TIMEOUT_DEFAULT = 64;

    // Little-endian byte lane select within a 16-bit word
    function automatic logic [7:0] byte_of(input sample_t word, input logic hi);
        return hi ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/fft_seq_ctrl.sv
// Byte-stream sequencer for the 4-point FFT engine: gathers eight input bytes into four
// samples, runs the engine, qualifies its sticky done and streams the four results back out.
module fft_seq_ctrl
    import fft_pkg::*;
#(
    parameter int ENG_LAT = ENG_LAT_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        err,
    output logic [15:0] fft_sample0,
    output logic [15:0] fft_sample1,
    output logic [15:0] fft_sample2,
    output logic [15:0] fft_sample3,
    output logic        fft_start,
    input  logic        fft_done,
    input  logic [15:0] fft_freq0,
    input  logic [15:0] fft_freq1,
    input  logic [15:0] fft_freq2,
    input  logic [15:0] fft_freq3
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int IDX_W = $clog2(BYTES_PER_FRAME);
    localparam logic [CNT_W-1:0] ENG_LAT_CNT = CNT_W'(ENG_LAT);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(BYTES_PER_FRAME - 1);

    ctrl_state_t      state;
    ctrl_state_t      next_state;
    logic [IDX_W-1:0] byte_idx;
    logic [IDX_W-1:0] next_idx;
    logic [CNT_W-1:0] wait_cnt;
    sample_t          sample_buf [4];
    sample_t          result_buf [4];

    logic last_byte;
    logic accept;
    logic capture;
    logic timeout;
    logic send;

    assign last_byte = (byte_idx == LAST_IDX);
    assign next_idx  = byte_idx + IDX_W'(1);

    assign in_ready = (state == LOAD);
    assign busy     = (state != LOAD);

    assign fft_sample0 = sample_buf[0];
    assign fft_sample1 = sample_buf[1];
    assign fft_sample2 = sample_buf[2];
    assign fft_sample3 = sample_buf[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    // Done is sticky from the previous run, so it only counts once ENG_LAT cycles have passed
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        capture    = 1'b0;
        timeout    = 1'b0;
        send       = 1'b0;
        case (state)
            LOAD: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (last_byte) begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (fft_done && (wait_cnt >= ENG_LAT_CNT)) begin
                    capture    = 1'b1;
                    next_state = DRAIN;
                end else if (wait_cnt == TIMEOUT_CNT) begin
                    timeout    = 1'b1;
                    next_state = LOAD;
                end
            end
            DRAIN: begin
                if (out_valid && out_ready) begin
                    send = 1'b1;
                    if (last_byte) begin
                        next_state = LOAD;
                    end
                end
            end
            default: next_state = LOAD;
        endcase
        if (clear) begin
            next_state = LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx  <= '0;
            wait_cnt  <= '0;
            fft_start <= 1'b0;
            out_valid <= 1'b0;
            out_byte  <= '0;
            err       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                sample_buf[i] <= '0;
                result_buf[i] <= '0;
            end
        end else if (clear) begin
            byte_idx  <= '0;
            wait_cnt  <= '0;
            fft_start <= 1'b0;
            out_valid <= 1'b0;
            out_byte  <= '0;
            err       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                sample_buf[i] <= '0;
                result_buf[i] <= '0;
            end
        end else begin
            if (accept) begin
                if (byte_idx[0]) begin
                    sample_buf[byte_idx[IDX_W-1:1]][15:8] <= in_byte;
                end else begin
                    sample_buf[byte_idx[IDX_W-1:1]][7:0] <= in_byte;
                end
                err <= 1'b0;
                if (last_byte) begin
                    byte_idx  <= '0;
                    wait_cnt  <= '0;
                    fft_start <= 1'b1;
                end else begin
                    byte_idx <= next_idx;
                end
            end

            if (state == WAIT) begin
                if (wait_cnt != TIMEOUT_CNT) begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                end
                if (capture) begin
                    result_buf[0] <= fft_freq0;
                    result_buf[1] <= fft_freq1;
                    result_buf[2] <= fft_freq2;
                    result_buf[3] <= fft_freq3;
                    fft_start     <= 1'b0;
                    out_valid     <= 1'b1;
                    out_byte      <= fft_freq0[7:0];
                end else if (timeout) begin
                    err       <= 1'b1;
                    fft_start <= 1'b0;
                    wait_cnt  <= '0;
                    for (int i = 0; i < 4; i++) begin
                        sample_buf[i] <= '0;
                    end
                end
            end

            if (send) begin
                if (last_byte) begin
                    out_valid <= 1'b0;
                    byte_idx  <= '0;
                end else begin
                    byte_idx <= next_idx;
                    out_byte <= byte_of(result_buf[next_idx[IDX_W-1:1]], next_idx[0]);
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Self-checking bench for fft_seq_ctrl: a behavioural engine model plus a frame-level
// reference built from the byte/word ordering rules, driven with random data.
module tb_fft_seq_ctrl;

    localparam int ENG_LAT = 5;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        err;
    logic [15:0] fft_sample0, fft_sample1, fft_sample2, fft_sample3;
    logic        fft_start;
    logic        fft_done;
    logic [15:0] fft_freq0, fft_freq1, fft_freq2, fft_freq3;

    logic [15:0] eng_freq [4];
    logic [7:0]  frame_bytes [8];
    logic [15:0] frame_freq [4];
    int          done_lat;
    bit          sticky;
    int          start_cnt;
    int          tests;
    int          failures;

    assign fft_freq0 = eng_freq[0];
    assign fft_freq1 = eng_freq[1];
    assign fft_freq2 = eng_freq[2];
    assign fft_freq3 = eng_freq[3];

    always #5 clk = ~clk;

    fft_seq_ctrl #(.ENG_LAT(ENG_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
        .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .err(err),
        .fft_sample0(fft_sample0), .fft_sample1(fft_sample1),
        .fft_sample2(fft_sample2), .fft_sample3(fft_sample3),
        .fft_start(fft_start), .fft_done(fft_done),
        .fft_freq0(fft_freq0), .fft_freq1(fft_freq1),
        .fft_freq2(fft_freq2), .fft_freq3(fft_freq3)
    );

    // Engine model: done rises done_lat cycles after start, drops when start drops
    initial begin
        fft_done  = 1'b0;
        start_cnt = 0;
        forever begin
            @(negedge clk);
            if (!fft_start) start_cnt = 0;
            else start_cnt++;
            if (sticky) fft_done = 1'b1;
            else fft_done = fft_start && (done_lat >= 0) && (start_cnt >= done_lat);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sends frame_bytes[first .. first+count-1]; starts and ends on a falling edge
    task automatic applyStimulus(input int first, input int count, input bit gaps);
        for (int k = first; k < first + count; k++) begin
            bit accepted = 1'b0;
            int budget = 0;
            for (int g = 0; g < 3 && gaps && ($urandom_range(0, 1) == 1); g++) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_byte  = frame_bytes[k];
            while (!accepted && budget < 200) begin
                bit rdy = in_ready;
                @(negedge clk);
                budget++;
                if (rdy) accepted = 1'b1;
            end
            if (!accepted) checkOutput("in_accept_timeout", 0, 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic drainOutput(input bit bp, input int count);
        int idx = 0;
        int cycles = 0;
        bit prev_stall = 1'b0;
        logic [7:0] prev_byte = '0;
        logic [7:0] exp_byte;
        while (idx < count && cycles < 400) begin
            if (prev_stall) begin
                checkOutput("hold_valid", out_valid, 1);
                checkOutput("hold_byte", out_byte, prev_byte);
            end
            out_ready = bp ? cycles[0] : 1'b1;
            if (out_valid && out_ready) begin
                exp_byte = (idx % 2 == 1) ? frame_freq[idx / 2][15:8] : frame_freq[idx / 2][7:0];
                checkOutput($sformatf("out_byte_%0d", idx), out_byte, exp_byte);
                idx++;
            end
            prev_stall = out_valid && !out_ready;
            prev_byte  = out_byte;
            @(negedge clk);
            cycles++;
        end
        out_ready = 1'b0;
        if (idx < count) checkOutput("drain_timeout", idx, count);
    endtask

    task automatic randomizeFrame();
        for (int i = 0; i < 8; i++) frame_bytes[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) frame_freq[i] = 16'($urandom);
    endtask

    task automatic runFrame(input int lat, input bit bp, input bit gaps, input int count);
        int n;
        int exp_first;
        logic [15:0] exp_s [4];
        for (int i = 0; i < 4; i++) begin
            exp_s[i]    = {frame_bytes[2*i+1], frame_bytes[2*i]};
            eng_freq[i] = frame_freq[i];
        end
        done_lat = lat;
        if (sticky) exp_first = ENG_LAT + 2;
        else exp_first = ((lat > ENG_LAT + 1) ? lat : ENG_LAT + 1) + 1;
        applyStimulus(0, 1, gaps);
        checkOutput("err_after_byte", err, 0);
        applyStimulus(1, 7, gaps);
        n = 1;
        checkOutput("start_after_last", fft_start, 1);
        checkOutput("busy_wait", busy, 1);
        checkOutput("in_ready_wait", in_ready, 0);
        checkOutput("sample0", fft_sample0, exp_s[0]);
        checkOutput("sample1", fft_sample1, exp_s[1]);
        checkOutput("sample2", fft_sample2, exp_s[2]);
        checkOutput("sample3", fft_sample3, exp_s[3]);
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("first_out_cycle", n, exp_first);
        checkOutput("start_low_drain", fft_start, 0);
        checkOutput("sample_stable", fft_sample2, exp_s[2]);
        for (int i = 0; i < 4; i++) eng_freq[i] = 16'($urandom);
        drainOutput(bp, count);
        if (count == 8) begin
            checkOutput("valid_after_drain", out_valid, 0);
            checkOutput("in_ready_after", in_ready, 1);
            checkOutput("busy_after", busy, 0);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_in_ready"}, in_ready, 1);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_out_valid"}, out_valid, 0);
        checkOutput({tag, "_out_byte"}, out_byte, 0);
        checkOutput({tag, "_start"}, fft_start, 0);
        checkOutput({tag, "_err"}, err, 0);
        checkOutput({tag, "_sample0"}, fft_sample0, 0);
    endtask

    initial begin
        int n;
        tests     = 0;
        failures  = 0;
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_byte   = '0;
        out_ready = 1'b0;
        sticky    = 1'b0;
        done_lat  = -1;
        for (int i = 0; i < 4; i++) eng_freq[i] = '0;
        repeat (2) @(negedge clk);
        checkIdle("reset");
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] basic frame");
        frame_bytes = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00};
        frame_freq  = '{16'h000A, 16'hFFFE, 16'hFFFE, 16'hFFFE};
        runFrame(5, 1'b0, 1'b0, 8);

        $display("[TB] sticky done");
        sticky = 1'b1;
        randomizeFrame();
        runFrame(0, 1'b0, 1'b0, 8);
        randomizeFrame();
        runFrame(0, 1'b0, 1'b0, 8);
        sticky = 1'b0;
        @(negedge clk);

        $display("[TB] backpressure and input gaps");
        for (int f = 0; f < 3; f++) begin
            randomizeFrame();
            runFrame(int'($urandom_range(ENG_LAT, 12)), 1'b1, 1'b1, 8);
        end

        $display("[TB] timeout");
        randomizeFrame();
        done_lat = -1;
        applyStimulus(0, 8, 1'b0);
        n = 1;
        while (n < TIMEOUT + 1) begin
            @(negedge clk);
            n++;
        end
        checkOutput("err_before_timeout", err, 0);
        checkOutput("start_before_timeout", fft_start, 1);
        @(negedge clk);
        checkOutput("err_timeout", err, 1);
        checkOutput("start_timeout", fft_start, 0);
        checkOutput("in_ready_timeout", in_ready, 1);
        checkOutput("busy_timeout", busy, 0);
        checkOutput("sample0_timeout", fft_sample0, 0);
        checkOutput("sample3_timeout", fft_sample3, 0);
        randomizeFrame();
        runFrame(6, 1'b0, 1'b1, 8);

        $display("[TB] abort in WAIT and DRAIN");
        randomizeFrame();
        frame_bytes[0] = 8'h5A;
        done_lat = -1;
        applyStimulus(0, 8, 1'b0);
        repeat (3) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checkIdle("clear_wait");
        randomizeFrame();
        frame_bytes[0] = 8'hC3;
        runFrame(6, 1'b0, 1'b0, 3);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checkIdle("clear_drain");
        randomizeFrame();
        runFrame(7, 1'b1, 1'b0, 8);

        $display("[TB] async reset mid-load");
        randomizeFrame();
        frame_bytes[0] = 8'hA5;
        applyStimulus(0, 5, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkIdle("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        randomizeFrame();
        runFrame(7, 1'b1, 1'b1, 8);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
